instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream stage of the multicycle controller. Owns the PC and the instruction register (IR).
- On request from the controller, reads one instruction word from the shared memory using a ready handshake, latches it into IR, advances the PC, and presents the opcode field to the controller.
- Accepts jump redirects from the controller at any time; a redirect that arrives mid-fetch is deferred and applied when that fetch completes.

Parameters:
- ADDR_WIDTH, 13, width of PC and memory address.
- DATA_WIDTH, 16, instruction word width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- fetch_start  in  1  one-cycle request from controller to fetch the next instruction.
- jump_en  in  1  load jump_target into PC.
- jump_target  in  ADDR_WIDTH  redirect address.
- mem_read  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory address; equals pc.
- mem_rdata  in  DATA_WIDTH  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the read in this cycle.
- instruction  out  DATA_WIDTH  IR contents.
- opcode  out  4  IR[DATA_WIDTH-1 -: 4]; feeds the controller decode.
- pc  out  ADDR_WIDTH  current PC.
- busy  out  1  high while in FETCH.
- instr_valid  out  1  IR holds a freshly fetched word not yet superseded.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, IR=0, pend_jump=0, pend_target=0.
  - Outputs: mem_read=0, busy=0, instr_valid=0.
- State IDLE: wait for fetch_start.
  - fetch_start=1 -> FETCH.
- State FETCH:
  - mem_read=1, mem_addr=pc, busy=1.
  - mem_ready=0 -> stay in FETCH, all registers hold.
  - mem_ready=1 -> IR<=mem_rdata, then -> VALID.
    - pc<=pend_target if pend_jump=1, else pc+1.
    - pend_jump<=0.
- State VALID:
  - instr_valid=1, mem_read=0.
  - fetch_start=1 -> FETCH, instr_valid drops the next cycle.
  - Otherwise stay in VALID; IR holds indefinitely.
- Latency:
  - fetch_start sampled at edge N -> mem_read high in cycle N+1.
  - mem_ready at edge N+1+k -> instr_valid high from cycle N+2+k.
  - Minimum is 2 cycles, with zero wait states.
- Jump in IDLE or VALID: pc<=jump_target at the next edge.
- Jump together with fetch_start in IDLE or VALID: pc<=jump_target and state<=FETCH on the same edge, so the fetch reads from jump_target.
- Jump in FETCH:
  - pc is not changed, so mem_addr stays stable during the handshake.
  - pend_jump<=1 and pend_target<=jump_target. The latest jump wins if several arrive.
  - jump_en together with mem_ready in the same cycle: jump_target is used directly as the new pc.
- fetch_start while in FETCH: ignored, not queued.
- PC arithmetic: pc+1 is modulo 2^ADDR_WIDTH, so the all-ones address wraps to 0.
- mem_addr and mem_read are driven from registered state. No combinational path exists from mem_ready to mem_read.
- Reset during FETCH:
  - The outstanding read is abandoned and mem_read drops immediately.
  - A late mem_ready after reset release, while in IDLE, is ignored.
- mem_rdata is sampled only when state=FETCH and mem_ready=1.

Decomposition:
- Shared package/defines file holds:
  - fetch state encodings IFU_IDLE, IFU_FETCH, IFU_VALID (2-bit);
  - the opcode field position constant;
  - RESET_PC default.
- One natural sub-module: pc_reg. It holds the PC register with an async active-low reset, and performs increment/load plus the pending-jump mux.
- IR and the FSM stay in the top module.

Test Plan:
- Reset, zero-wait fetch: release rst, pulse fetch_start, mem_ready=1 with mem_rdata=16'hA123 -> mem_read high one cycle at addr 0; instruction=16'hA123, opcode=4'hA, pc=1, instr_valid=1 two cycles after fetch_start.
- Wait states: mem_ready held low 3 cycles, then high with 16'h5F00 -> mem_addr stable at pc for 4 cycles, busy=1 throughout; IR=16'h5F00 and pc incremented exactly once.
- Jump in VALID plus fetch: jump_en=1 with jump_target=13'h0100 and fetch_start=1 on the same edge -> next mem_addr=13'h0100; afterwards pc=13'h0101.
- Jump mid-fetch: jump_en with target 13'h0200 during a wait state, then mem_ready -> mem_addr unchanged during the wait; pc=13'h0200 after completion, not pc+1.
- Wrap: jump to 13'h1FFF, then fetch -> mem_addr=13'h1FFF; pc becomes 0.
- Reset mid-fetch: assert rst=0 asynchronously while in FETCH -> mem_read=0 and instr_valid=0 immediately; pc=RESET_PC; a later mem_ready pulse in IDLE leaves IR=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings, opcode field
// geometry and the default reset PC.
package instr_fetch_unit_pkg;

   localparam logic [1:0] IFU_IDLE  = 2'd0;
   localparam logic [1:0] IFU_FETCH = 2'd1;
   localparam logic [1:0] IFU_VALID = 2'd2;

   localparam int unsigned IFU_OPCODE_W = 4;
   localparam int unsigned IFU_RESET_PC = 0;

   // Opcode occupies the top IFU_OPCODE_W bits of a 16-bit instruction word.
   function automatic logic [IFU_OPCODE_W-1:0] ifu_opcode16(input logic [15:0] word);
      return word[15 -: IFU_OPCODE_W];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with increment/load and a pending-jump slot that defers
// redirects arriving while a memory read is outstanding.
module pc_reg #(
   parameter int          ADDR_WIDTH = 13,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_fetch_i,
   input  logic                  mem_ready_i,
   input  logic                  jump_en_i,
   input  logic [ADDR_WIDTH-1:0] jump_target_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  pend_jump_q, pend_jump_d;
   logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
   logic                  fetch_done;

   assign fetch_done = in_fetch_i & mem_ready_i;

   always_comb begin
      pc_d          = pc_q;
      pend_jump_d   = pend_jump_q;
      pend_target_d = pend_target_q;
      if (fetch_done) begin
         // A same-cycle jump beats an older pending one; otherwise step.
         if (jump_en_i) begin
            pc_d = jump_target_i;
         end else if (pend_jump_q) begin
            pc_d = pend_target_q;
         end else begin
            pc_d = pc_q + 1'b1;
         end
         pend_jump_d = 1'b0;
      end else if (in_fetch_i) begin
         // Keep the address stable during the handshake; remember the latest jump.
         if (jump_en_i) begin
            pend_jump_d   = 1'b1;
            pend_target_d = jump_target_i;
         end
      end else if (jump_en_i) begin
         pc_d = jump_target_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q          <= ADDR_WIDTH'(RESET_PC);
         pend_jump_q   <= 1'b0;
         pend_target_q <= '0;
      end else begin
         pc_q          <= pc_d;
         pend_jump_q   <= pend_jump_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch FSM and IR, reads one word per request
// over a ready handshake and hands the opcode to the controller.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          ADDR_WIDTH = 13,
   parameter int          DATA_WIDTH = 16,
   parameter int unsigned RESET_PC   = IFU_RESET_PC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fetch_start,
   input  logic                    jump_en,
   input  logic [ADDR_WIDTH-1:0]   jump_target,
   output logic                    mem_read,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ready,
   output logic [DATA_WIDTH-1:0]   instruction,
   output logic [IFU_OPCODE_W-1:0] opcode,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic                    busy,
   output logic                    instr_valid
);

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic                  in_fetch;
   logic [ADDR_WIDTH-1:0] pc_w;

   assign in_fetch = (state_q == IFU_FETCH);

   pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .clk_i         (clk),
      .rst_ni        (rst),
      .in_fetch_i    (in_fetch),
      .mem_ready_i   (mem_ready),
      .jump_en_i     (jump_en),
      .jump_target_i (jump_target),
      .pc_o          (pc_w)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IFU_IDLE:  if (fetch_start) state_d = IFU_FETCH;
         IFU_FETCH: if (mem_ready)   state_d = IFU_VALID;
         IFU_VALID: if (fetch_start) state_d = IFU_FETCH;
         default:   state_d = IFU_IDLE;
      endcase
   end

   // IR only ever captures data on a completed handshake.
   always_comb begin
      ir_d = ir_q;
      if (in_fetch && mem_ready) begin
         ir_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IFU_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   assign mem_read    = in_fetch;
   assign busy        = in_fetch;
   assign mem_addr    = pc_w;
   assign pc          = pc_w;
   assign instr_valid = (state_q == IFU_VALID);
   assign instruction = ir_q;
   assign opcode      = ir_q[DATA_WIDTH-1 -: IFU_OPCODE_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised self-checking bench for instr_fetch_unit with a behavioural model
// plus directed literal checks of the documented scenarios.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start, jump_en, mem_ready;
   logic [12:0] jump_target;
   logic [15:0] mem_rdata;
   logic        mem_read, busy, instr_valid;
   logic [12:0] mem_addr, pc;
   logic [15:0] instruction;
   logic [3:0]  opcode;

   int n_cmp = 0;
   int n_fail = 0;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .jump_en     (jump_en),
      .jump_target (jump_target),
      .mem_read    (mem_read),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .instruction (instruction),
      .opcode      (opcode),
      .pc          (pc),
      .busy        (busy),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   // Behavioural model: "waiting" means a read is outstanding, "have" means a
   // fresh word sits in IR; a deferred jump is kept as an optional target.
   logic        m_waiting = 1'b0;
   logic        m_have = 1'b0;
   logic [12:0] m_pc = 13'd0;
   logic [15:0] m_ir = 16'd0;
   logic        m_defer = 1'b0;
   logic [12:0] m_defer_to = 13'd0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_waiting  <= 1'b0;
         m_have     <= 1'b0;
         m_pc       <= 13'd0;
         m_ir       <= 16'd0;
         m_defer    <= 1'b0;
         m_defer_to <= 13'd0;
      end else if (m_waiting) begin
         if (mem_ready) begin
            m_ir      <= mem_rdata;
            m_waiting <= 1'b0;
            m_have    <= 1'b1;
            m_defer   <= 1'b0;
            m_pc      <= jump_en ? jump_target : (m_defer ? m_defer_to : 13'((m_pc + 1) % 8192));
         end else if (jump_en) begin
            m_defer    <= 1'b1;
            m_defer_to <= jump_target;
         end
      end else begin
         if (jump_en) m_pc <= jump_target;
         if (fetch_start) begin
            m_waiting <= 1'b1;
            m_have    <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("mem_read", 32'(mem_read), 32'(m_waiting));
      chk("busy", 32'(busy), 32'(m_waiting));
      chk("instr_valid", 32'(instr_valid), 32'(m_have));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("instruction", 32'(instruction), 32'(m_ir));
      chk("opcode", 32'(opcode), 32'(m_ir[15:12]));
   end

   task automatic cyc(input logic fs, input logic je, input logic [12:0] jt,
                      input logic rdy, input logic [15:0] rd);
      fetch_start = fs;
      jump_en     = je;
      jump_target = jt;
      mem_ready   = rdy;
      mem_rdata   = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      fetch_start = 1'b0;
      jump_en = 1'b0;
      jump_target = 13'd0;
      mem_ready = 1'b0;
      mem_rdata = 16'd0;
      #12;
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_ir", 32'(instruction), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // zero-wait fetch
      cyc(1'b1, 1'b0, 13'd0, 1'b0, 16'd0);
      chk("zw_mem_read", 32'(mem_read), 32'd1);
      chk("zw_addr", 32'(mem_addr), 32'd0);
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 16'hA123);
      chk("zw_ir", 32'(instruction), 32'hA123);
      chk("zw_opcode", 32'(opcode), 32'hA);
      chk("zw_pc", 32'(pc), 32'd1);
      chk("zw_valid", 32'(instr_valid), 32'd1);
      chk("zw_mem_read_off", 32'(mem_read), 32'd0);

      // three wait states
      cyc(1'b1, 1'b0, 13'd0, 1'b0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 13'd0, 1'b0, 16'hFFFF);
         chk("ws_addr", 32'(mem_addr), 32'd1);
         chk("ws_busy", 32'(busy), 32'd1);
      end
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 16'h5F00);
      chk("ws_ir", 32'(instruction), 32'h5F00);
      chk("ws_pc", 32'(pc), 32'd2);

      // jump together with fetch_start from VALID
      cyc(1'b1, 1'b1, 13'h0100, 1'b0, 16'd0);
      chk("jf_addr", 32'(mem_addr), 32'h0100);
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 16'h1234);
      chk("jf_pc", 32'(pc), 32'h0101);

      // jump during a wait state is deferred
      cyc(1'b1, 1'b0, 13'd0, 1'b0, 16'd0);
      cyc(1'b0, 1'b1, 13'h0200, 1'b0, 16'd0);
      chk("jm_addr_hold", 32'(mem_addr), 32'h0101);
      cyc(1'b0, 1'b0, 13'd0, 1'b0, 16'd0);
      chk("jm_addr_hold2", 32'(mem_addr), 32'h0101);
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 16'h2222);
      chk("jm_pc", 32'(pc), 32'h0200);

      // jump in the completing cycle wins
      cyc(1'b1, 1'b0, 13'd0, 1'b0, 16'd0);
      cyc(1'b0, 1'b1, 13'h0333, 1'b1, 16'h3333);
      chk("jr_pc", 32'(pc), 32'h0333);

      // wrap at the top of the address space
      cyc(1'b0, 1'b1, 13'h1FFF, 1'b0, 16'd0);
      cyc(1'b1, 1'b0, 13'd0, 1'b0, 16'd0);
      chk("wr_addr", 32'(mem_addr), 32'h1FFF);
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 16'h7777);
      chk("wr_pc", 32'(pc), 32'd0);

      // asynchronous reset in the middle of a fetch
      cyc(1'b1, 1'b0, 13'd0, 1'b0, 16'd0);
      #2 rst = 1'b0;
      #1;
      chk("ar_mem_read", 32'(mem_read), 32'd0);
      chk("ar_valid", 32'(instr_valid), 32'd0);
      chk("ar_pc", 32'(pc), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc(1'b0, 1'b0, 13'd0, 1'b1, 16'hBEEF);
      chk("ar_late_ir", 32'(instruction), 32'd0);
      chk("ar_late_valid", 32'(instr_valid), 32'd0);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
             13'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
